// File: rtl/frame_deserializer.sv
// Multi-channel frame deserializer: captures NUM_CH words per frame-sync envelope,
// commits only exact-length frames, and drains them one channel per valid/ready beat.
module frame_deserializer #(
    parameter  int DATA_W    = 22,
    parameter  int NUM_CH    = 1,
    parameter  int LSB_FIRST = 0,
    parameter  int ERR_CNT_W = 8,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst_b,
    input  logic                     serial_in,
    input  logic                     frame_sync_in,
    output logic signed [DATA_W-1:0] parallel_out,
    output logic [CH_W-1:0]          ch_out,
    output logic                     data_valid,
    input  logic                     data_ready,
    output logic                     frame_done,
    output logic                     len_err,
    output logic                     overrun_err,
    output logic [ERR_CNT_W-1:0]     err_count,
    input  logic                     clr_err
);

    localparam int TOTAL = NUM_CH * DATA_W;
    localparam int CNT_W = $clog2(TOTAL + 2);
    localparam int WB_W  = $clog2(DATA_W);
    localparam int IDX_W = $clog2(NUM_CH + 1);

    logic                r_fs_d1;
    logic [CNT_W-1:0]    r_bit_cnt;
    logic [WB_W-1:0]     r_word_bit;
    logic [IDX_W-1:0]    r_word_idx;
    logic [DATA_W-1:0]   r_shift;
    logic [DATA_W-1:0]   r_staging [NUM_CH];
    logic [DATA_W-1:0]   r_bank    [NUM_CH];
    logic [CH_W-1:0]     r_rd_ch;
    logic                r_busy;
    logic                r_frame_done;
    logic                r_len_err;
    logic                r_overrun_err;
    logic [ERR_CNT_W-1:0] r_err_count;

    logic [DATA_W-1:0]   w_shift_nxt;
    logic [DATA_W-1:0]   w_par;
    logic                w_edge;
    logic                w_len_ok;
    logic                w_hs;
    logic                w_last;
    logic                w_bank_free;
    logic                w_commit;
    logic                w_len_ev;
    logic                w_ovr_ev;
    logic                w_err_ev;

    assign w_shift_nxt = (LSB_FIRST != 0) ? {serial_in, r_shift[DATA_W-1:1]}
                                          : {r_shift[DATA_W-2:0], serial_in};

    assign w_edge      = r_fs_d1 & ~frame_sync_in;
    assign w_len_ok    = (r_bit_cnt == CNT_W'(TOTAL));
    assign w_hs        = r_busy & data_ready;
    assign w_last      = (r_rd_ch == CH_W'(NUM_CH - 1));
    // A bank emptied by this cycle's last handshake can take the new frame at once.
    assign w_bank_free = ~r_busy | (w_hs & w_last);
    assign w_commit    = w_edge & w_len_ok & w_bank_free;
    assign w_len_ev    = w_edge & ~w_len_ok;
    assign w_ovr_ev    = w_edge & w_len_ok & ~w_bank_free;
    assign w_err_ev    = w_len_ev | w_ovr_ev;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_fs_d1    <= 1'b0;
            r_bit_cnt  <= '0;
            r_word_bit <= '0;
            r_word_idx <= '0;
            r_shift    <= '0;
            for (int c = 0; c < NUM_CH; c++) r_staging[c] <= '0;
        end else begin
            r_fs_d1 <= frame_sync_in;
            if (frame_sync_in) begin
                r_shift <= w_shift_nxt;
                if (r_bit_cnt != CNT_W'(TOTAL + 1)) r_bit_cnt <= r_bit_cnt + 1'b1;
                if (r_word_bit == WB_W'(DATA_W - 1)) begin
                    r_word_bit <= '0;
                    if (r_word_idx != IDX_W'(NUM_CH)) r_word_idx <= r_word_idx + 1'b1;
                    for (int c = 0; c < NUM_CH; c++) begin
                        if (r_word_idx == IDX_W'(c)) r_staging[c] <= w_shift_nxt;
                    end
                end else begin
                    r_word_bit <= r_word_bit + 1'b1;
                end
            end else begin
                r_bit_cnt  <= '0;
                r_word_bit <= '0;
                r_word_idx <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_busy        <= 1'b0;
            r_rd_ch       <= '0;
            r_frame_done  <= 1'b0;
            r_len_err     <= 1'b0;
            r_overrun_err <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) r_bank[c] <= '0;
        end else begin
            r_frame_done  <= 1'b0;
            r_len_err     <= w_len_ev;
            r_overrun_err <= w_ovr_ev;
            if (w_hs) begin
                if (w_last) begin
                    r_busy       <= 1'b0;
                    r_rd_ch      <= '0;
                    r_frame_done <= 1'b1;
                end else begin
                    r_rd_ch <= r_rd_ch + 1'b1;
                end
            end
            if (w_commit) begin
                for (int c = 0; c < NUM_CH; c++) r_bank[c] <= r_staging[c];
                r_busy  <= 1'b1;
                r_rd_ch <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_err_count <= '0;
        end else if (clr_err) begin
            r_err_count <= w_err_ev ? ERR_CNT_W'(1) : '0;
        end else if (w_err_ev && (r_err_count != '1)) begin
            r_err_count <= r_err_count + 1'b1;
        end
    end

    always_comb begin
        w_par = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (r_rd_ch == CH_W'(c)) w_par = r_bank[c];
        end
    end

    assign parallel_out = w_par;
    assign ch_out       = r_rd_ch;
    assign data_valid   = r_busy;
    assign frame_done   = r_frame_done;
    assign len_err      = r_len_err;
    assign overrun_err  = r_overrun_err;
    assign err_count    = r_err_count;

endmodule
